// File: rtl/regwrite_arbiter_pkg.sv
// rtl/regwrite_arbiter_pkg.sv - shared ID-stage types for the register write-port arbiter
//
// Contents:
//   arb_state_e : arbiter state encoding (IDLE, GRANT_WB, GRANT_MD)
//   OWNER_WB    : owner value naming the writeback pipe
//   OWNER_MD    : owner value naming the multicycle mul/div unit
package regwrite_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_WB = 2'd1,
        ST_GRANT_MD = 2'd2
    } arb_state_e;

    localparam logic OWNER_WB = 1'b0;
    localparam logic OWNER_MD = 1'b1;

endpackage

// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - arbitrates WB and MD write requests onto the single register_bank write port
//
// Ports:
//   clock, reset                   : rising-edge clock, asynchronous active-high reset
//   wb_valid/wb_rw/wb_data/wb_ready: writeback pipe request and accept
//   md_valid/md_rw/md_data/md_ready: mul/div unit request and accept
//   reg_write/rw/busw              : registered write port into register_bank
//   owner                          : last granted requester (0 = WB, 1 = MD)
module regwrite_arbiter
    import regwrite_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rw,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        md_valid,
    input  logic [4:0]  md_rw,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        reg_write,
    output logic [4:0]  rw,
    output logic [31:0] busw,
    output logic        owner
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] BURST_ONE = CW'(1);

    arb_state_e     state_q, state_d;
    logic [CW-1:0]  burst_q, burst_d;
    logic           owner_q, owner_d;
    logic           reg_write_q, reg_write_d;
    logic [4:0]     rw_q, rw_d;
    logic [31:0]    busw_q, busw_d;

    logic           grant_wb;
    logic           grant_md;
    logic           transfer;
    logic [4:0]     sel_rw;
    logic [31:0]    sel_data;
    logic [CW-1:0]  burst_inc;

    assign burst_inc = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_ONE;

    // Grant decision: the holder keeps the port until it goes idle or has used
    // its burst allowance while the other side is waiting.
    always_comb begin
        grant_wb = 1'b0;
        grant_md = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_valid && md_valid) begin
                    if (owner_q == OWNER_MD) grant_wb = 1'b1;
                    else                     grant_md = 1'b1;
                end else if (wb_valid) begin
                    grant_wb = 1'b1;
                end else if (md_valid) begin
                    grant_md = 1'b1;
                end
            end
            ST_GRANT_WB: begin
                if (wb_valid && (!md_valid || burst_q < BURST_MAX)) grant_wb = 1'b1;
                else if (md_valid)                                  grant_md = 1'b1;
            end
            ST_GRANT_MD: begin
                if (md_valid && (!wb_valid || burst_q < BURST_MAX)) grant_md = 1'b1;
                else if (wb_valid)                                  grant_wb = 1'b1;
            end
            default: begin
                grant_wb = 1'b0;
                grant_md = 1'b0;
            end
        endcase
        // Nothing may be accepted while reset holds the write port cleared.
        if (reset) begin
            grant_wb = 1'b0;
            grant_md = 1'b0;
        end
    end

    assign transfer = grant_wb | grant_md;
    assign sel_rw   = grant_md ? md_rw   : wb_rw;
    assign sel_data = grant_md ? md_data : wb_data;

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        owner_d     = owner_q;
        reg_write_d = 1'b0;
        rw_d        = rw_q;
        busw_d      = busw_q;

        if (grant_wb) begin
            state_d = ST_GRANT_WB;
            owner_d = OWNER_WB;
            burst_d = (state_q == ST_GRANT_WB) ? burst_inc : BURST_ONE;
        end else if (grant_md) begin
            state_d = ST_GRANT_MD;
            owner_d = OWNER_MD;
            burst_d = (state_q == ST_GRANT_MD) ? burst_inc : BURST_ONE;
        end else begin
            state_d = ST_IDLE;
        end

        // A transfer to r0 is accepted but suppressed at the write enable.
        if (transfer) begin
            reg_write_d = (sel_rw != 5'd0);
            rw_d        = sel_rw;
            busw_d      = sel_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            burst_q     <= '0;
            owner_q     <= OWNER_MD;
            reg_write_q <= 1'b0;
            rw_q        <= 5'd0;
            busw_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            owner_q     <= owner_d;
            reg_write_q <= reg_write_d;
            rw_q        <= rw_d;
            busw_q      <= busw_d;
        end
    end

    assign wb_ready  = grant_wb;
    assign md_ready  = grant_md;
    assign reg_write = reg_write_q;
    assign rw        = rw_q;
    assign busw      = busw_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - self-checking bench for regwrite_arbiter
module tb_regwrite_arbiter;

    localparam int MAX_BURST = 4;

    logic        clock;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rw;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        md_valid;
    logic [4:0]  md_rw;
    logic [31:0] md_data;
    logic        md_ready;
    logic        reg_write;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic        owner;

    int n_checks;
    int n_fail;

    // Reference model: who was granted last, whether the previous cycle
    // granted anyone, and how many grants in a row the last winner has had.
    logic        m_last;
    logic        m_active;
    int          m_run;
    int          last_win;   // 0 = none, 1 = WB, 2 = MD
    logic        exp_w;
    logic [4:0]  exp_rw;
    logic [31:0] exp_busw;

    regwrite_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clock     (clock),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_rw     (wb_rw),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .md_valid  (md_valid),
        .md_rw     (md_rw),
        .md_data   (md_data),
        .md_ready  (md_ready),
        .reg_write (reg_write),
        .rw        (rw),
        .busw      (busw),
        .owner     (owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
        int   win;
        logic who;
        wb_valid = wv; wb_rw = wr; wb_data = wd;
        md_valid = mv; md_rw = mr; md_data = md;
        #1;
        if (!wv && !mv)          win = 0;
        else if (wv && !mv)      win = 1;
        else if (!wv && mv)      win = 2;
        else if (!m_active)      win = m_last ? 1 : 2;
        else if (m_run < MAX_BURST) win = m_last ? 2 : 1;
        else                     win = m_last ? 1 : 2;

        chk1("wb_ready", wb_ready, win == 1);
        chk1("md_ready", md_ready, win == 2);
        chk1("ready_exclusive", wb_ready && md_ready, 1'b0);

        exp_w = 1'b0;
        if (win != 0) begin
            who = (win == 2);
            m_run = (m_active && who == m_last) ? ((m_run + 1 > MAX_BURST) ? MAX_BURST : m_run + 1) : 1;
            m_last = who;
            exp_rw   = who ? mr : wr;
            exp_busw = who ? md : wd;
            exp_w    = (exp_rw != 5'd0);
        end
        m_active = (win != 0);
        last_win = win;

        @(posedge clock);
        #1;
        chk1("reg_write", reg_write, exp_w);
        chk1("no_r0_write", reg_write && (rw == 5'd0), 1'b0);
        if (exp_w) begin
            chk32("rw", 32'(rw), 32'(exp_rw));
            chk32("busw", busw, exp_busw);
        end
        if (win != 0) chk1("owner", owner, m_last);
        @(negedge clock);
    endtask

    // Called at a falling edge; asserts reset across one rising edge with the
    // inputs left as they were, so any pending request must be dropped.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk1("rst_wb_ready", wb_ready, 1'b0);
        chk1("rst_md_ready", md_ready, 1'b0);
        chk1("rst_reg_write", reg_write, 1'b0);
        chk32("rst_rw", 32'(rw), 32'd0);
        chk32("rst_busw", busw, 32'd0);
        chk1("rst_owner", owner, 1'b1);
        @(posedge clock);
        #1;
        chk1("rst_reg_write_after_edge", reg_write, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        m_last   = 1'b1;
        m_active = 1'b0;
        m_run    = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        wb_valid = 1'b0; wb_rw = 5'd0; wb_data = 32'd0;
        md_valid = 1'b0; md_rw = 5'd0; md_data = 32'd0;
        m_last = 1'b1; m_active = 1'b0; m_run = 0; last_win = 0;
        exp_w = 1'b0; exp_rw = 5'd0; exp_busw = 32'd0;

        @(negedge clock);
        do_reset();

        // Single request to r5.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk32("single_rw", 32'(rw), 32'd5);
        chk32("single_busw", busw, 32'hDEADBEEF);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset mid-grant with WB still requesting; WB must win afterwards.
        step(1'b1, 5'd9, 32'h1111_0001, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd9, 32'h1111_0002, 1'b1, 5'd10, 32'h2222_0001);
        do_reset();
        step(1'b1, 5'd11, 32'h1111_0003, 1'b1, 5'd12, 32'h2222_0002);
        chk32("post_reset_first_grant", 32'(last_win), 32'd1);

        // Burst limit: WBx4, MDx4, WBx4 with both requesting continuously.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i), 1'b1, 5'(i + 16), 32'hB000_0000 + 32'(i));
            chk32("burst_seq", 32'(last_win), ((i / 4) % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Register 0 write from MD is accepted but not written.
        do_reset();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFE_F00D);
        chk1("r0_md_accepted", m_active, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Handover: WB drops while MD waits; MD starts a fresh burst of 4.
        do_reset();
        step(1'b1, 5'd3, 32'h3333_0001, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd3, 32'h3333_0002, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777_0001);
        chk32("handover_grant", 32'(last_win), 32'd2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd4, 32'h4444_0000 + 32'(i), 1'b1, 5'd8, 32'h8888_0000 + 32'(i));
            chk32("handover_burst", 32'(last_win), (i < 3) ? 32'd2 : 32'd1);
        end

        // Random stress against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7,
                     ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                     $urandom,
                     $urandom_range(0, 9) < 7,
                     ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                     $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive grants to one requester while the other is requesting.
REQ-003 clock  input  1  rising-edge clock shared with register_bank.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wb_valid  input  1  writeback pipe write request.
REQ-006 wb_rw  input  5  writeback destination register.
REQ-007 wb_data  input  32  writeback data.
REQ-008 wb_ready  output  1  writeback request accepted this cycle.
REQ-009 md_valid  input  1  multicycle mul/div unit write request.
REQ-010 md_rw  input  5  mul/div destination register.
REQ-011 md_data  input  32  mul/div result.
REQ-012 md_ready  output  1  mul/div request accepted this cycle.
REQ-013 reg_write  output  1  write enable to register_bank.
REQ-014 rw  output  5  write address to register_bank.
REQ-015 busw  output  32  write data to register_bank.
REQ-016 owner  output  1  last granted requester: 0 = WB, 1 = MD.

Function
REQ-017 A request SHALL transfer when valid and ready are both high in the same cycle.
REQ-018 At most one of wb_ready and md_ready SHALL be high in any cycle.
REQ-019 ready SHALL be combinational from the valids and the arbiter state; ready SHALL be low whenever the matching valid is low.
REQ-020 The arbiter state machine SHALL have states IDLE, GRANT_WB and GRANT_MD, and SHALL also keep a burst counter of $clog2(MAX_BURST+1) bits.
REQ-021 In IDLE, if both requesters are valid, the one not named by owner SHALL win (round-robin); a single valid requester SHALL win.
REQ-022 In GRANT_X, X SHALL keep the grant while X is valid and either the other requester is idle or the burst count is below MAX_BURST.
REQ-023 In GRANT_X, once X has been granted MAX_BURST times in a row with the other requester valid, the grant SHALL pass to the other requester.
REQ-024 In GRANT_X, if X is not valid, the other requester SHALL be granted in the same cycle when it is valid; otherwise the state SHALL return to IDLE.
REQ-025 The burst counter SHALL reset to 1 when the grant changes owner, increment on each repeated grant, and saturate at MAX_BURST.
REQ-026 reg_write, rw and busw SHALL be registered: each accepted transfer appears on them exactly 1 cycle later, for exactly 1 cycle.
REQ-027 A transfer with rw = 0 SHALL be accepted, and reg_write SHALL stay 0 for it, so that register 0 is never written.
REQ-028 In a cycle with no transfer, reg_write SHALL be 0 and rw and busw SHALL hold their previous values.
REQ-029 owner SHALL update on each accepted transfer.

Reset
REQ-030 While reset is asserted: state = IDLE, burst counter = 0, owner = 1 (so WB wins the first tie), reg_write = 0, rw = 0, busw = 0.
REQ-031 wb_ready and md_ready SHALL be 0 while reset is asserted.
REQ-032 A transfer in flight when reset asserts SHALL be discarded, and no write SHALL occur after reset deasserts.

Structure
REQ-033 The state encoding and the WB/MD owner constants SHALL live in the shared ID-stage package.
REQ-034 There SHALL be no sub-module; the output register and the arbiter SHALL be in one module.
REQ-035 The outputs SHALL connect directly to register_bank ports reg_write, rw and busw.

Verification
REQ-036 Reset mid-grant: wb_valid held high, then reset pulses -> reg_write = 0 the cycle after reset; the first grant after release goes to WB.
REQ-037 Single request: wb_valid for 1 cycle with rw = 5, data = 0xDEADBEEF -> wb_ready = 1 in that cycle; next cycle reg_write = 1, rw = 5, busw = 0xDEADBEEF.
REQ-038 Burst limit: both valid continuously, MAX_BURST = 4 -> grant sequence WB×4, MD×4, WB×4, with one write per cycle and no idle gaps.
REQ-039 Register 0: md_valid with md_rw = 0 -> md_ready = 1, and reg_write stays 0 the following cycle.
REQ-040 Handover: WB holds the grant, wb_valid drops while md_valid is high -> md_ready = 1 in that same cycle, and the burst counter = 1.
REQ-041 Random stress: reg_write is never high for rw = 0, the two readys are never high together, and every accepted transfer is written exactly once in order.
